bifrost_regs: RTL

Bus-target register block in the Bifröst CPLD, answering CPU cycles in the I/O window qualified by the active-low chip select from the address decoder. Provides an ID byte, a scratch register and a 16-bit interval timer with reload latch, a sticky expiry flag and an open-drain-style IRQ. Runs on the fast system clock and treats the 6502 bus (phi2, rw, addr, data) as asynchronous inputs, committing side effects on the synchronised phi2 falling edge.

---
 rtl/bifrost_regs_if.sv | 21 ++
 rtl/bifrost_regs.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bifrost_regs_if.sv
// 6502-side bus bundle for the Bifrost register block: CPU strobes in, read data and IRQ out.
interface bifrost_regs_if;
   logic       phi2;
   logic       cs_n;
   logic       rw;
   logic [3:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;
   logic       irq_n;

   modport master (
      output phi2, cs_n, rw, addr, data_in,
      input  data_out, data_oe, irq_n
   );

   modport slave (
      input  phi2, cs_n, rw, addr, data_in,
      output data_out, data_oe, irq_n
   );
endinterface

// File: rtl/bifrost_regs.sv
// Bifrost CPU register block: ID, scratch, 16-bit interval timer with reload latch and IRQ.
// The 6502 bus is asynchronous; side effects commit on the synchronised phi2 falling edge.
module bifrost_regs #(
   parameter int         PRESCALE = 1,
   parameter logic [7:0] ID_VALUE = 8'hB1
) (
   input  logic          clock,
   input  logic          reset,
   bifrost_regs_if.slave bus
);

   localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

   logic        phi2_p0, phi2_p1, phi2_p2;
   logic        commit;
   logic        cs_n_p1, rw_p1;
   logic [3:0]  addr_p1;
   logic [7:0]  data_p1;
   logic        en, ie, auto_rl, exp_flag, irq_q;
   logic [15:0] latch, cnt;
   logic [7:0]  shadow, scratch, presc;
   logic        tick, expire;
   logic        wr_en, rd_en;
   logic [7:0]  rd_data;

   function automatic logic [15:0] dec_sat(input logic [15:0] v);
      return (v == 16'h0000) ? 16'h0000 : v - 16'h0001;
   endfunction

   // Stage p0/p1: phi2 synchroniser; p2: delayed copy for falling-edge detect
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phi2_p0 <= 1'b0;
         phi2_p1 <= 1'b0;
         phi2_p2 <= 1'b0;
      end else begin
         phi2_p0 <= bus.phi2;
         phi2_p1 <= phi2_p0;
         phi2_p2 <= phi2_p1;
      end
   end

   assign commit = phi2_p2 & ~phi2_p1;

   // Stage p1: bus capture while synchronised phi2 is high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_n_p1 <= 1'b1;
         rw_p1   <= 1'b1;
         addr_p1 <= 4'h0;
         data_p1 <= 8'h00;
      end else if (phi2_p1) begin
         cs_n_p1 <= bus.cs_n;
         rw_p1   <= bus.rw;
         addr_p1 <= bus.addr;
         data_p1 <= bus.data_in;
      end
   end

   assign wr_en  = commit & ~cs_n_p1 & ~rw_p1;
   assign rd_en  = commit & ~cs_n_p1 & rw_p1;
   assign tick   = en && (presc == PRESC_LAST);
   assign expire = tick && (cnt == 16'h0000);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         presc <= 8'h00;
      else if (!en || tick)
         presc <= 8'h00;
      else
         presc <= presc + 8'h01;
   end

   // Commit stage: register writes, read side effects and timer update share one edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en       <= 1'b0;
         ie       <= 1'b0;
         auto_rl  <= 1'b0;
         exp_flag <= 1'b0;
         latch    <= 16'h0000;
         cnt      <= 16'h0000;
         shadow   <= 8'h00;
         scratch  <= 8'h00;
         irq_q    <= 1'b1;
      end else begin
         // A THI load wins over both reload and decrement on the same edge
         if (wr_en && addr_p1 == 4'd4)
            cnt <= {data_p1, latch[7:0]};
         else if (expire)
            cnt <= auto_rl ? latch : 16'h0000;
         else if (tick)
            cnt <= dec_sat(cnt);

         if (wr_en && addr_p1 == 4'd3) latch[7:0]  <= data_p1;
         if (wr_en && addr_p1 == 4'd4) latch[15:8] <= data_p1;

         if (wr_en && addr_p1 == 4'd1)
            {auto_rl, ie, en} <= data_p1[2:0];
         else if (expire)
            en <= auto_rl;

         if (expire)
            exp_flag <= 1'b1;
         else if (wr_en && addr_p1 == 4'd2 && data_p1[0])
            exp_flag <= 1'b0;

         if (rd_en && addr_p1 == 4'd5) shadow  <= cnt[15:8];
         if (wr_en && addr_p1 == 4'd7) scratch <= data_p1;

         irq_q <= ~(exp_flag & ie);
      end
   end

   assign bus.data_oe = ~bus.cs_n & bus.rw & bus.phi2;

   always_comb begin
      rd_data = 8'h00;
      case (bus.addr)
         4'd0:    rd_data = ID_VALUE;
         4'd1:    rd_data = {5'b00000, auto_rl, ie, en};
         4'd2:    rd_data = {7'b0000000, exp_flag};
         4'd3:    rd_data = latch[7:0];
         4'd4:    rd_data = latch[15:8];
         4'd5:    rd_data = cnt[7:0];
         4'd6:    rd_data = shadow;
         4'd7:    rd_data = scratch;
         default: rd_data = 8'h00;
      endcase
   end

   assign bus.data_out = bus.data_oe ? rd_data : 8'h00;
   assign bus.irq_n    = irq_q;

endmodule
